fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS lab pipeline. It owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word plus PC+4 into the IF/ID pipeline register consumed by the decode stage. It honours hazard-unit freezes and branch redirects/flushes resolved downstream.

---
 rtl/fetch_stage.sv | 48 ++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID pipeline register, honouring freezes and branch flushes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign inst_addr = pc;

    // Priority on every edge: rst > branch_taken > freeze > normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            id_pc       <= 32'h0;
            id_inst     <= 32'h0;
            id_valid    <= 1'b0;
            fetch_count <= 32'h0;
        end else if (branch_taken) begin
            // Wrong-path word is dropped; the flush bubble is an all-zero NOP.
            pc       <= {branch_addr[31:2], 2'b00};
            id_pc    <= 32'h0;
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
        end else if (!freeze) begin
            pc          <= pc_plus4;
            id_pc       <= pc_plus4;
            id_inst     <= inst_in;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequences followed by random
// freeze/branch/reset traffic, checked against a reference model via a queue.
module tb_fetch_stage;

    localparam int W = 129;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] fetch_count;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic [31:0] m_count;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .inst_addr    (inst_addr),
        .inst_in      (inst_in),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .fetch_count  (fetch_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: word[n] = n + 100
    assign inst_in = (inst_addr >> 2) + 32'd100;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd100;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: one clock edge with the given controls; model result queued.
    task automatic step(input logic r, input logic fr, input logic br, input logic [31:0] ba);
        logic [W-1:0] e;
        @(negedge clk);
        rst          = r;
        freeze       = fr;
        branch_taken = br;
        branch_addr  = ba;
        if (r) begin
            m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_count = 32'h0;
        end else if (br) begin
            m_pc = {ba[31:2], 2'b00}; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
        end else if (!fr) begin
            m_id_inst  = mem_word(m_pc);
            m_id_pc    = m_pc + 32'd4;
            m_id_valid = 1'b1;
            m_pc       = m_pc + 32'd4;
            m_count    = m_count + 32'd1;
        end
        exp_q.push_back({m_id_valid, m_pc, m_id_pc, m_id_inst, m_count});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("inst_addr",   inst_addr,            e[127:96]);
        check_val("id_pc",       id_pc,                e[95:64]);
        check_val("id_inst",     id_inst,              e[63:32]);
        check_val("fetch_count", fetch_count,          e[31:0]);
        check_val("id_valid",    {31'h0, id_valid},    {31'h0, e[128]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_count = 32'h0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("rst_inst_addr", inst_addr, 32'h0);
        check_val("rst_count", fetch_count, 32'h0);

        // Sequential fetch
        run(4);
        check_val("seq_id_inst", id_inst, 32'd103);
        check_val("seq_id_pc", id_pc, 32'd16);
        check_val("seq_inst_addr", inst_addr, 32'd16);
        check_val("seq_count", fetch_count, 32'd4);

        // Freeze after two fetches
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("frz_inst_addr", inst_addr, 32'd8);
        check_val("frz_id_inst", id_inst, 32'd101);
        check_val("frz_count", fetch_count, 32'd2);
        run(1);
        check_val("frz_release_inst", id_inst, 32'd102);

        // Branch with flush at PC=20
        run(2);
        check_val("pre_br_pc", inst_addr, 32'd20);
        step(1'b0, 1'b0, 1'b1, 32'h0000_00B6);
        check_val("br_inst_addr", inst_addr, 32'h0000_00B4);
        check_val("br_valid", {31'h0, id_valid}, 32'h0);
        run(1);
        check_val("br_target_inst", id_inst, 32'd145);
        check_val("br_target_pc", id_pc, 32'h0000_00B8);

        // Branch during freeze
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        check_val("brfrz_pc", inst_addr, 32'h0000_0040);
        run(10);

        // Reset mid-run overrides freeze and branch
        step(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        check_val("midrst_count", fetch_count, 32'h0);
        run(1);
        check_val("midrst_first_inst", id_inst, 32'd100);

        // PC wrap
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(1);
        check_val("wrap_inst_addr", inst_addr, 32'h0);
        check_val("wrap_id_pc", id_pc, 32'h0);
        run(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom());
        end

        check_val("queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
